// File: rtl/seq_recon_multiplier_8x8.sv
// seq_recon_multiplier_8x8
//
// Sequential shift-add multiplier that rebuilds a 16-bit dividend from an
// 8-bit quotient, divisor and remainder: n = q*d + r. One multiplier bit is
// consumed per cycle, LSB first, so every operation takes a fixed 8 RUN cycles.
// The lowest APPROX_COLS accumulator columns can use an approximate lower-OR
// adder cell (sum = a | b, no carry chain between those columns).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   q          quotient / multiplier operand, captured on input handshake
//   d          divisor / multiplicand, captured on input handshake
//   r          remainder, initial accumulator value (zero-extended)
//   in_valid   operands valid
//   in_ready   block can accept operands (forced low while rst is high)
//   n          reconstructed dividend, held until the next result is loaded
//   out_valid  n is valid
//   out_ready  consumer accepts n
module seq_recon_multiplier_8x8 #(
  parameter int unsigned APPROX_COLS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  q,
  input  logic [7:0]  d,
  input  logic [7:0]  r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] n,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state;
  logic [7:0]  q_reg;
  logic [7:0]  d_reg;
  logic [15:0] acc;
  logic [2:0]  cnt;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        add_en;
  logic        carry;

  assign add_en = q_reg[cnt];
  assign addend = {8'h00, d_reg} << cnt;

  // Combinational reset gate keeps in_ready low during the whole reset window.
  assign in_ready = (state == StIdle) && !rst;

  // 16-bit adder: approximate lower-OR columns below APPROX_COLS, exact full
  // adders above. Carry into the first exact column is a&b of the top
  // approximate column; carry out of bit 15 is dropped.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < APPROX_COLS) begin
        sum[i] = acc[i] | addend[i];
        carry  = acc[i] & addend[i];
      end else begin
        sum[i] = acc[i] ^ addend[i] ^ carry;
        carry  = (acc[i] & addend[i]) | (carry & (acc[i] ^ addend[i]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      q_reg     <= '0;
      d_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      n         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            q_reg <= q;
            d_reg <= d;
            acc   <= {8'h00, r};
            cnt   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          if (add_en) begin
            acc <= sum;
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            n         <= add_en ? sum : acc;
            out_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule
